alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one `alu` instance between two requesters through a valid/ready request handshake.
- Two-stage pipeline:
  - stage 1 registers the granted operands;
  - stage 2 registers the ALU result plus the requester ID.
- Sits between the two issue sources of the datapath (e.g. main pipeline and address/branch unit) and the single ALU.
- Sustains one accepted request per cycle.

Parameters:
- FAIR, 1: 1 = round-robin between requesters; 0 = fixed priority, req0 always wins.
- INIT_PRIO, 0: requester that wins the first contention after reset when FAIR=1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 accepted this cycle
- req0_op1  input  32  operand 1
- req0_op2  input  32  operand 2
- req0_alu_op  input  4  ALU operation code
- req1_valid, req1_ready, req1_op1, req1_op2, req1_alu_op: same widths and meaning for requester 1
- resp0_valid  output  1  resp_result/resp_zero belong to requester 0 (1-cycle pulse)
- resp1_valid  output  1  same, for requester 1
- resp_result  output  32  registered ALU result
- resp_zero  output  1  registered ALU zero flag
- busy  output  1  stage 1 or stage 2 holds a valid entry

Behaviour:
- Clock and reset:
  - One clock `clk`. Reset `rst` is synchronous and active-high.
  - Every register is sampled only on the rising edge of `clk`.
- Reset values, effective the cycle after `rst` is sampled high:
  - resp0_valid = 0, resp1_valid = 0, resp_result = 0, resp_zero = 0, busy = 0.
  - Stage-1 valid = 0.
  - Last-grant pointer = !INIT_PRIO, so INIT_PRIO wins next.
- Reset mid-operation: in-flight entries are discarded and no response pulse is produced. While rst=1, req0_ready = req1_ready = 0.
- Grant, combinational from valids and pointer:
  - Only one valid: that requester gets ready=1.
  - Both valid, FAIR=1: grant the requester that is not the last-grant pointer.
  - Both valid, FAIR=0: grant req0.
  - Never both ready in one cycle.
  - Ready may depend on own valid. Requesters must not make valid depend on ready.
- Accept: valid && ready at a rising edge.
  - Latches op1, op2, alu_op and ID into stage 1 and sets stage-1 valid.
  - The pointer updates to the accepted ID on every accept.
- Stage 2: the `alu` combinationally evaluates the stage-1 operands. Next edge:
  - resp_result ← alu.result and resp_zero ← alu.zero;
  - respN_valid ← stage-1 valid && ID==N.
- Latency: accept at edge T gives respN_valid=1 during cycle T+2 → T+3, a single-cycle pulse.
- Throughput: back-to-back accepts produce back-to-back pulses. No back-pressure on responses; requesters must consume the pulse.
- Hold: resp_result and resp_zero hold their last value when no response is issued. The valids drop to 0.
- Idle: no valid request → stage-1 valid clears. Operands are not cleared.
- busy = stage-1 valid | resp0_valid | resp1_valid.
- Widths:
  - All data is 32-bit with no widening.
  - ADD/SUB wrap modulo 2^32.
  - Shift amounts use op2[4:0].
  - Unknown alu_op gives result 0 and zero=1, inherited from the ALU.
- Starvation: with FAIR=1 and both requesters continuously valid, grants strictly alternate.

Decomposition:
- Shared package `alu_pkg` holds:
  - the ALU opcode constants: AND 0000, OR 0001, ADD 0010, SUB 0110, LESS 0100, SRL 1000, SLL 1001, SRA 1010, XOR 0101;
  - the requester-ID constants REQ0=0, REQ1=1.
- One natural sub-module: `alu_rr_grant`, a 2-way grant plus pointer. It is instantiated beside the existing `alu`, which is reused unchanged.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then no requests for 5 cycles.
  - Required: both readys 0 during reset; all outputs 0 and busy=0 throughout.
- Single requester, ADD:
  - Stimulus: req0 ADD with op1=5, op2=7 accepted at edge T.
  - Required: resp0_valid=1 and resp_result=12, resp_zero=0 in cycle T+2; resp1_valid=0.
- Contention, FAIR=1, INIT_PRIO=0:
  - Stimulus: both requesters valid continuously for 4 cycles; req0 SUB 9-9, req1 LESS 0xFFFFFFFF,1.
  - Required: grants go req0, req1, req0, req1.
  - Required: each req0 response has result 0 and zero=1; each req1 response has result 1.
- Fixed priority, FAIR=0:
  - Stimulus: both valid for 3 cycles, then req0 drops.
  - Required: req0 is granted 3 times, then req1 on the 4th cycle.
- Back-to-back with reset:
  - Stimulus: req1 SRA with op1=0x80000000, op2=4, then XOR 0xF0F0F0F0 ^ 0xFFFFFFFF on consecutive edges.
  - Required: consecutive resp1 pulses with 0xF8000000, then 0x0F0F0F0F.
  - Stimulus: repeat, asserting rst the cycle after the 2nd accept.
  - Required: no pulse for the 2nd request; outputs return to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, requester IDs and datapath widths for the ALU
// and the arbiter that shares it.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_LESS = 4'b0100;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'b1000;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'b1001;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'b1010;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'b0101;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Unknown opcodes produce result 0 (and so zero=1).
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    logic signed [DATA_W-1:0] op1_s;
    logic signed [DATA_W-1:0] op2_s;

    assign op1_s = op1;
    assign op2_s = op2;

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_AND:  result = op1 & op2;
            ALU_OR:   result = op1 | op2;
            ALU_ADD:  result = op1 + op2;
            ALU_SUB:  result = op1 - op2;
            ALU_LESS: result = {{(DATA_W-1){1'b0}}, (op1_s < op2_s)};
            ALU_SRL:  result = op1 >> op2[4:0];
            ALU_SLL:  result = op1 << op2[4:0];
            ALU_SRA:  result = $unsigned(op1_s >>> op2[4:0]);
            ALU_XOR:  result = op1 ^ op2;
            default:  result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_rr_grant.sv
// Two-way grant with a last-grant pointer: round-robin when FAIR, otherwise
// requester 0 always wins. No grant is issued while reset is asserted.
module alu_rr_grant
    import alu_pkg::*;
#(
    parameter bit FAIR      = 1'b1,
    parameter bit INIT_PRIO = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    output logic ready0,
    output logic ready1,
    output logic accept,
    output logic grant_id
);

    logic last_q;

    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (!rst) begin
            if (valid0 && valid1) begin
                if (FAIR && (last_q == REQ0)) ready1 = 1'b1;
                else                          ready0 = 1'b1;
            end else begin
                ready0 = valid0;
                ready1 = valid1;
            end
        end
        accept   = ready0 | ready1;
        grant_id = ready1 ? REQ1 : REQ0;
    end

    // Pointer starts at the loser so INIT_PRIO wins the first contention.
    always_ff @(posedge clk) begin
        if (rst)         last_q <= ~INIT_PRIO;
        else if (accept) last_q <= grant_id;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: grant and operand mux, stage-1
// operand register, stage-2 result register with a per-requester valid pulse.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit FAIR      = 1'b1,
    parameter bit INIT_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [OP_W-1:0]   req0_alu_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [OP_W-1:0]   req1_alu_op,
    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero,
    output logic              busy
);

    logic              accept;
    logic              grant_id;
    logic [DATA_W-1:0] op1_p0;
    logic [DATA_W-1:0] op2_p0;
    logic [OP_W-1:0]   alu_op_p0;

    logic              vld_p1;
    logic              id_p1;
    logic [DATA_W-1:0] op1_p1;
    logic [DATA_W-1:0] op2_p1;
    logic [OP_W-1:0]   alu_op_p1;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    logic              resp0_vld_p2;
    logic              resp1_vld_p2;
    logic [DATA_W-1:0] result_p2;
    logic              zero_p2;

    alu_rr_grant #(
        .FAIR      (FAIR),
        .INIT_PRIO (INIT_PRIO)
    ) u_grant (
        .clk      (clk),
        .rst      (rst),
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .ready0   (req0_ready),
        .ready1   (req1_ready),
        .accept   (accept),
        .grant_id (grant_id)
    );

    always_comb begin
        op1_p0    = req0_op1;
        op2_p0    = req0_op2;
        alu_op_p0 = req0_alu_op;
        if (grant_id == REQ1) begin
            op1_p0    = req1_op1;
            op2_p0    = req1_op2;
            alu_op_p0 = req1_alu_op;
        end
    end

    // ---- stage 1: granted operands ----
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            id_p1     <= grant_id;
            op1_p1    <= op1_p0;
            op2_p1    <= op2_p0;
            alu_op_p1 <= alu_op_p0;
        end
    end

    alu u_alu (
        .op1    (op1_p1),
        .op2    (op2_p1),
        .alu_op (alu_op_p1),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // ---- stage 2: result, flag and requester pulse ----
    always_ff @(posedge clk) begin
        if (rst) begin
            resp0_vld_p2 <= 1'b0;
            resp1_vld_p2 <= 1'b0;
            result_p2    <= '0;
            zero_p2      <= 1'b0;
        end else begin
            resp0_vld_p2 <= vld_p1 && (id_p1 == REQ0);
            resp1_vld_p2 <= vld_p1 && (id_p1 == REQ1);
            if (vld_p1) begin
                result_p2 <= alu_result;
                zero_p2   <= alu_zero;
            end
        end
    end

    assign resp0_valid = resp0_vld_p2;
    assign resp1_valid = resp1_vld_p2;
    assign resp_result = result_p2;
    assign resp_zero   = zero_p2;
    assign busy        = vld_p1 | resp0_vld_p2 | resp1_vld_p2;

endmodule
